// File: rtl/button_conditioner_pkg.sv
// Shared helpers for the button conditioner slice.
// Contents: maxOf    - larger of two ints
//           cntWidth - counter width able to hold 0..maxVal, never less than 1
package button_conditioner_pkg;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw pins, the conditioner and its consumers.
// Signals: btn_raw     - asynchronous raw buttons, active high
//          btn_level   - debounced level, 1 = held
//          btn_press   - 1-cycle pulse on accepted 0->1
//          btn_release - 1-cycle pulse on accepted 1->0
//          btn_repeat  - 1-cycle auto-repeat pulse while held
// Modports: master = the conditioner (drives the conditioned outputs),
//           slave  = the pin/consumer side.
interface button_conditioner_if #(
  parameter int N = 5
);
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_repeat;

  modport master (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_repeat
  );

  modport slave (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_repeat
  );
endinterface

// File: rtl/button_channel.sv
// One button: 2-FF synchronizer, counter debounce, press/release pulses
// and hold auto-repeat FSM.
// Ports: clk, resetn (synchronous, active low)
//        btnRaw     - raw async button
//        btnLevel   - debounced level
//        btnPress   - pulse in the first cycle btnLevel reads 1
//        btnRelease - pulse in the first cycle btnLevel reads 0
//        btnRepeat  - auto-repeat pulse while held
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic btnRaw,
  output logic btnLevel,
  output logic btnPress,
  output logic btnRelease,
  output logic btnRepeat
);

  localparam int DW = cntWidth(DEBOUNCE_CYCLES);
  localparam int RW = cntWidth(maxOf(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  // DELAY is unreachable when REPEAT_DELAY is 0, so the clamp only keeps the constant legal.
  localparam logic [RW-1:0] RD_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repState_e;

  logic            s1, s2;
  logic [DW-1:0]   dcnt;
  repState_e       state, stateNext;
  logic [RW-1:0]   rcnt, rcntNext;
  logic            repNext;
  logic            differs, accept, acceptRise, acceptFall;

  assign differs    = (s2 != btnLevel);
  assign accept     = differs && (dcnt == D_LAST);
  assign acceptRise = accept && s2;
  assign acceptFall = accept && !s2;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      dcnt       <= '0;
      btnLevel   <= 1'b0;
      btnPress   <= 1'b0;
      btnRelease <= 1'b0;
      btnRepeat  <= 1'b0;
      state      <= IDLE;
      rcnt       <= '0;
    end else begin
      s1         <= btnRaw;
      s2         <= s1;
      // Pulses are registered alongside btnLevel so they align with the new level.
      btnPress   <= acceptRise;
      btnRelease <= acceptFall;
      btnRepeat  <= repNext;
      state      <= stateNext;
      rcnt       <= rcntNext;
      if (!differs) begin
        dcnt <= '0;
      end else if (accept) begin
        btnLevel <= s2;
        dcnt     <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  always_comb begin
    stateNext = state;
    rcntNext  = rcnt;
    repNext   = 1'b0;
    case (state)
      IDLE: begin
        if (acceptRise && (REPEAT_DELAY != 0)) begin
          stateNext = DELAY;
          rcntNext  = '0;
        end
      end
      DELAY: begin
        if (rcnt == RD_LAST) begin
          repNext   = 1'b1;
          rcntNext  = '0;
          stateNext = REPEAT;
        end else begin
          rcntNext = rcnt + RW'(1);
        end
      end
      REPEAT: begin
        if (rcnt == RP_LAST) begin
          repNext  = 1'b1;
          rcntNext = '0;
        end else begin
          rcntNext = rcnt + RW'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        rcntNext  = '0;
      end
    endcase
    // A release cancels the repeat, including one expiring in this very cycle.
    if (acceptFall) begin
      stateNext = IDLE;
      rcntNext  = '0;
      repNext   = 1'b0;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N raw push buttons for the LED / 7-segment stage.
// Ports: clk    - 100 MHz system clock
//        resetn - synchronous active-low reset
//        bus    - button bundle (master side): btn_raw in; btn_level,
//                 btn_press, btn_release, btn_repeat out
// Each bit is handled by an independent button_channel.
module button_conditioner #(
  parameter int N               = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input logic                  clk,
  input logic                  resetn,
  button_conditioner_if.master bus
);

  logic [N-1:0] level, press, rel, rep;

  for (genvar g = 0; g < N; g++) begin : gCh
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) uCh (
      .clk       (clk),
      .resetn    (resetn),
      .btnRaw    (bus.btn_raw[g]),
      .btnLevel  (level[g]),
      .btnPress  (press[g]),
      .btnRelease(rel[g]),
      .btnRepeat (rep[g])
    );
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel;
  assign bus.btn_repeat  = rep;

endmodule
